// File: rtl/pc_report_tx.sv
// Frames a captured result snapshot as SOF, LEN, 20-byte body, CSUM over a valid/ready byte stream.
// SOF is presented one cycle after the request; ready low holds the byte; a long stall aborts the packet.
module pc_report_tx #(
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter logic [7:0]  PKT_TYPE       = 8'h52,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        report_req,
    input  logic [15:0] error_count,
    input  logic [31:0] min_latency,
    input  logic [31:0] max_latency,
    input  logic [31:0] avg_latency,
    input  logic [31:0] throughput,
    output logic        pc_rsp_valid,
    output logic [7:0]  pc_rsp_data,
    input  logic        pc_rsp_ready,
    output logic        busy,
    output logic        pkt_done,
    output logic        tx_timeout,
    output logic        req_dropped,
    output logic [7:0]  seq_num
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SOF  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_BODY = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;

    localparam logic [7:0]  LEN_BYTE = 8'h14;
    localparam logic [4:0]  LAST_IDX = 5'd19;
    localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 1;

    logic [2:0]  state;
    logic [4:0]  idx;
    logic [7:0]  csum;
    logic [31:0] stall_cnt;

    logic [15:0] cur_err;
    logic [31:0] cur_min, cur_max, cur_avg, cur_thr;
    logic        pending;
    logic [15:0] pend_err;
    logic [31:0] pend_min, pend_max, pend_avg, pend_thr;

    logic        xfer;
    logic        stalled;
    logic        timeout_hit;
    logic        csum_xfer;
    logic        start;
    logic [7:0]  body_b [20];

    assign pc_rsp_valid = (state != S_IDLE);
    assign busy         = (state != S_IDLE);
    assign xfer         = pc_rsp_valid && pc_rsp_ready;
    assign stalled      = pc_rsp_valid && !pc_rsp_ready;
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && stalled && (stall_cnt == TO_LAST);
    assign csum_xfer    = (state == S_CSUM) && xfer;
    // A request arriving with the CSUM transfer starts the next packet directly when no snapshot waits.
    assign start        = ((state == S_IDLE) && report_req) ||
                          (csum_xfer && (pending || report_req));

    always_comb begin
        body_b[0] = PKT_TYPE;
        body_b[1] = seq_num;
        body_b[2] = cur_err[15:8];
        body_b[3] = cur_err[7:0];
        for (int k = 0; k < 4; k++) begin
            body_b[4 + k]  = cur_min[8*(3-k) +: 8];
            body_b[8 + k]  = cur_max[8*(3-k) +: 8];
            body_b[12 + k] = cur_avg[8*(3-k) +: 8];
            body_b[16 + k] = cur_thr[8*(3-k) +: 8];
        end
    end

    always_comb begin
        pc_rsp_data = 8'h00;
        case (state)
            S_SOF:   pc_rsp_data = SOF_BYTE;
            S_LEN:   pc_rsp_data = LEN_BYTE;
            S_BODY:  pc_rsp_data = body_b[idx];
            S_CSUM:  pc_rsp_data = 8'h00 - csum;
            default: pc_rsp_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= 5'd0;
            csum        <= 8'h00;
            stall_cnt   <= 32'd0;
            seq_num     <= 8'h00;
            pkt_done    <= 1'b0;
            tx_timeout  <= 1'b0;
            req_dropped <= 1'b0;
            pending     <= 1'b0;
            cur_err     <= 16'h0;
            cur_min     <= 32'h0;
            cur_max     <= 32'h0;
            cur_avg     <= 32'h0;
            cur_thr     <= 32'h0;
            pend_err    <= 16'h0;
            pend_min    <= 32'h0;
            pend_max    <= 32'h0;
            pend_avg    <= 32'h0;
            pend_thr    <= 32'h0;
        end else begin
            pkt_done    <= 1'b0;
            tx_timeout  <= 1'b0;
            req_dropped <= 1'b0;

            if ((state == S_IDLE) || xfer) begin
                stall_cnt <= 32'd0;
            end else if (stalled) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            if (timeout_hit) begin
                state      <= S_IDLE;
                pending    <= 1'b0;
                tx_timeout <= 1'b1;
            end else begin
                case (state)
                    S_SOF: begin
                        if (xfer) state <= S_LEN;
                    end
                    S_LEN: begin
                        if (xfer) begin
                            csum  <= csum + pc_rsp_data;
                            idx   <= 5'd0;
                            state <= S_BODY;
                        end
                    end
                    S_BODY: begin
                        if (xfer) begin
                            csum <= csum + pc_rsp_data;
                            if (idx == LAST_IDX) state <= S_CSUM;
                            else                 idx   <= idx + 5'd1;
                        end
                    end
                    S_CSUM: begin
                        if (xfer) begin
                            seq_num  <= seq_num + 8'd1;
                            pkt_done <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                    default: ;
                endcase

                if (start) begin
                    state   <= S_SOF;
                    csum    <= 8'h00;
                    pending <= 1'b0;
                    cur_err <= pending ? pend_err : error_count;
                    cur_min <= pending ? pend_min : min_latency;
                    cur_max <= pending ? pend_max : max_latency;
                    cur_avg <= pending ? pend_avg : avg_latency;
                    cur_thr <= pending ? pend_thr : throughput;
                end

                if (report_req && (state != S_IDLE)) begin
                    if (pending) begin
                        req_dropped <= 1'b1;
                    end else if (!csum_xfer) begin
                        pending  <= 1'b1;
                        pend_err <= error_count;
                        pend_min <= min_latency;
                        pend_max <= max_latency;
                        pend_avg <= avg_latency;
                        pend_thr <= throughput;
                    end
                end
            end
        end
    end

endmodule
